// File: rtl/systolic_mul_gen.sv
`default_nettype none
// ============================================================================
// Module      : systolic_mul_gen
// Description : Output-stationary NxN systolic matrix multiplier. One
//               column of A and one row of B arrive per accepted beat; the
//               block skews them internally so A[i][k] and B[k][j] meet in
//               PE(i,j). Each PE holds C[i][j] in its own accumulator.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i       in   1              clock, rising edge
//   rst_ni      in   1              asynchronous active-low reset
//   start_i     in   1              begin a job (sampled in IDLE only)
//   acc_mode_i  in   1              1: C += A*B, 0: C = A*B (sampled w/ start)
//   valid_i     in   1              a_col_i / b_row_i beat valid
//   a_col_i     in   N*DATA_WIDTH   column k of A, slice i = A[i][k]
//   b_row_i     in   N*DATA_WIDTH   row k of B, slice j = B[k][j]
//   ready_o     out  1              beat accepted this cycle when valid_i
//   busy_o      out  1              job in progress (not IDLE)
//   done_o      out  1              one-cycle pulse, result_o complete
//   result_o    out  N*N*ACC_WIDTH  slice (i*N+j) = C[i][j]
// ============================================================================
module systolic_mul_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       acc_mode_i,
  input  logic                       valid_i,
  input  logic [N*DATA_WIDTH-1:0]    a_col_i,
  input  logic [N*DATA_WIDTH-1:0]    b_row_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [N*N*ACC_WIDTH-1:0]   result_o
);

  localparam int BEAT_W  = $clog2(N);
  localparam int DRAIN_W = $clog2(2 * N);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(N - 1);
  // The last operand pair reaches PE(N-1,N-1) 2N-2 edges after the final beat.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * N - 3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;

  logic                accept;
  logic                clear_acc;
  logic [N*DATA_WIDTH-1:0] feed_a;
  logic [N*DATA_WIDTH-1:0] feed_b;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          beat_d  = '0;
          drain_d = '0;
        end
      end
      S_LOAD: begin
        if (valid_i) begin
          if (beat_q == BEAT_LAST) begin
            state_d = S_DRAIN;
            beat_d  = '0;
            drain_d = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready_o = (state_q == S_LOAD);
  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);

  assign accept    = (state_q == S_LOAD) && valid_i;
  assign clear_acc = (state_q == S_IDLE) && start_i && !acc_mode_i;

  // Anything that is not an accepted beat enters the array as zero, so
  // bubbles and idle cycles contribute nothing to the accumulators.
  assign feed_a = accept ? a_col_i : '0;
  assign feed_b = accept ? b_row_i : '0;

  // --------------------------------------------------------------------------
  // Input skew: row i of A and column i of B are delayed by i cycles.
  // --------------------------------------------------------------------------
  logic [N-1:0][DATA_WIDTH-1:0] a_edge;
  logic [N-1:0][DATA_WIDTH-1:0] b_edge;

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = feed_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_edge[gi] = feed_b[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] a_sr_q [gi];
      logic [DATA_WIDTH-1:0] b_sr_q [gi];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int s = 0; s < gi; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          a_sr_q[0] <= feed_a[gi*DATA_WIDTH +: DATA_WIDTH];
          b_sr_q[0] <= feed_b[gi*DATA_WIDTH +: DATA_WIDTH];
          for (int s = 1; s < gi; s++) begin
            a_sr_q[s] <= a_sr_q[s-1];
            b_sr_q[s] <= b_sr_q[s-1];
          end
        end
      end

      assign a_edge[gi] = a_sr_q[gi-1];
      assign b_edge[gi] = b_sr_q[gi-1];
    end
  end

  // --------------------------------------------------------------------------
  // PE array. a travels right, b travels down; the last column/row has no
  // consumer downstream, so only N-1 pass registers exist per row/column.
  // --------------------------------------------------------------------------
  logic [N-1:0][N-2:0][DATA_WIDTH-1:0] a_pass;
  logic [N-2:0][N-1:0][DATA_WIDTH-1:0] b_pass;

  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in;
      logic [DATA_WIDTH-1:0] b_in;
      logic [ACC_WIDTH-1:0]  prod;
      logic [ACC_WIDTH-1:0]  acc_q;

      if (gc == 0) begin : g_a_edge
        assign a_in = a_edge[gr];
      end else begin : g_a_chain
        assign a_in = a_pass[gr][gc-1];
      end

      if (gr == 0) begin : g_b_edge
        assign b_in = b_edge[gc];
      end else begin : g_b_chain
        assign b_in = b_pass[gr-1][gc];
      end

      if (gc < N - 1) begin : g_a_reg
        logic [DATA_WIDTH-1:0] a_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) a_q <= '0;
          else         a_q <= a_in;
        end
        assign a_pass[gr][gc] = a_q;
      end

      if (gr < N - 1) begin : g_b_reg
        logic [DATA_WIDTH-1:0] b_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) b_q <= '0;
          else         b_q <= b_in;
        end
        assign b_pass[gr][gc] = b_q;
      end

      // Operands widened to the accumulator width: product and sum wrap
      // modulo 2^ACC_WIDTH.
      assign prod = ACC_WIDTH'(a_in) * ACC_WIDTH'(b_in);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          acc_q <= '0;
        end else if (clear_acc) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_q + prod;
        end
      end

      assign result_o[(gr*N+gc)*ACC_WIDTH +: ACC_WIDTH] = acc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mul_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_mul_gen
// Description : Self-checking bench for systolic_mul_gen (N=4 and N=2 builds).
//               Expected results come from a plain matrix-arithmetic model and
//               are queued at stimulus time; monitors compare on done_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mul_gen;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int N2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start, acc_mode, valid;
  logic [N*DW-1:0] a_col, b_row;
  logic ready, busy, done;
  logic [N*N*AW-1:0] result;

  logic start2, acc_mode2, valid2;
  logic [N2*DW-1:0] a_col2, b_row2;
  logic ready2, busy2, done2;
  logic [N2*N2*AW-1:0] result2;

  systolic_mul_gen #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .acc_mode_i(acc_mode),
    .valid_i(valid), .a_col_i(a_col), .b_row_i(b_row), .ready_o(ready),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  systolic_mul_gen #(.DATA_WIDTH(DW), .N(N2), .ACC_WIDTH(AW)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .acc_mode_i(acc_mode2),
    .valid_i(valid2), .a_col_i(a_col2), .b_row_i(b_row2), .ready_o(ready2),
    .busy_o(busy2), .done_o(done2), .result_o(result2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N*N*AW-1:0] res;
    int                done_cyc;
  } exp1_t;
  typedef struct {
    logic [N2*N2*AW-1:0] res;
    int                  done_cyc;
  } exp2_t;

  exp1_t q1[$];
  exp2_t q2[$];

  // Reference model state
  logic [DW-1:0]     A [N][N];
  logic [DW-1:0]     B [N][N];
  longint unsigned   C_m [N][N];
  int                stall [N];
  int                last_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor1();
    exp1_t e;
    int bad;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done_o=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          bad = -1;
          for (int x = 0; x < N*N; x++)
            if (bad < 0 && result[x*AW +: AW] !== e.res[x*AW +: AW]) bad = x;
          n_vec++;
          if (bad >= 0) begin
            n_err++;
            $display("FAIL result C[%0d][%0d]: got %0h expected %0h", bad / N, bad % N,
                     result[bad*AW +: AW], e.res[bad*AW +: AW]);
          end
          chk("done_latency", 64'(cyc), 64'(e.done_cyc));
        end
      end
    end
  endtask

  task automatic monitor2();
    exp2_t e;
    forever begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        if (q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done_n2: got done_o=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q2.pop_front();
          for (int x = 0; x < N2*N2; x++)
            chk("result_n2", result2[x*AW +: AW], e.res[x*AW +: AW]);
          chk("done_latency_n2", 64'(cyc), 64'(e.done_cyc));
        end
      end
    end
  endtask

  function automatic logic [N*N*AW-1:0] pack_model();
    logic [N*N*AW-1:0] r;
    for (int x = 0; x < N*N; x++) r[x*AW +: AW] = C_m[x / N][x % N];
    return r;
  endfunction

  // Issue one job on the N=4 instance; push the expectation when push_exp.
  task automatic feed_job(input bit accm, input bit push_exp);
    exp1_t e;
    @(posedge clk); #1;
    start = 1'b1; acc_mode = accm;
    @(posedge clk); #1;
    start = 1'b0; acc_mode = 1'($urandom);
    if (!accm)
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) C_m[i][j] = 0;
    for (int k = 0; k < N; k++) begin
      for (int s = 0; s < stall[k]; s++) begin
        valid = 1'b0;
        a_col = {N{$urandom}};
        b_row = {N{$urandom}};
        @(negedge clk);
        chk("ready_in_bubble", 64'(ready), 64'd1);
        @(posedge clk); #1;
      end
      valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = A[i][k];
        b_row[i*DW +: DW] = B[k][i];
      end
      @(negedge clk);
      if (k == 0) chk("busy_in_load", 64'(busy), 64'd1);
      last_acc = cyc;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    a_col = {N{$urandom}};
    b_row = {N{$urandom}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          C_m[i][j] += longint'(A[i][k]) * longint'(B[k][j]);
    if (push_exp) begin
      e.res = pack_model();
      e.done_cyc = last_acc + 2*N - 1;
      q1.push_back(e);
    end
  endtask

  // Wait into the expected DONE cycle, hold start_i there, confirm no relaunch.
  task automatic finish_job();
    int target;
    target = last_acc + 2*N - 1;
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    start = 1'b1; acc_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("scoreboard_drained", 64'(q1.size()), 64'd0);
    q1.delete();
  endtask

  task automatic no_stall();
    for (int k = 0; k < N; k++) stall[k] = 0;
  endtask

  initial begin
    exp2_t e2;
    int    t2;
    rst_n = 1'b0;
    start = 1'b0; acc_mode = 1'b0; valid = 1'b0; a_col = '0; b_row = '0;
    start2 = 1'b0; acc_mode2 = 1'b0; valid2 = 1'b0; a_col2 = '0; b_row2 = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) C_m[i][j] = 0;
    fork
      monitor1();
      monitor2();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(|result), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: A[i][k]=4i+k+1, B[k][j]=j+1
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = DW'(4*i + k + 1);
        B[i][k] = DW'(k + 1);
      end
    no_stall();
    feed_job(1'b0, 1'b1);
    finish_job();
    chk("dir_C00", result[0*AW +: AW], 64'd10);
    chk("dir_C03", result[3*AW +: AW], 64'd40);
    chk("dir_C30", result[12*AW +: AW], 64'd58);
    chk("dir_C33", result[15*AW +: AW], 64'd232);

    // Same job accumulated: doubles every element
    feed_job(1'b1, 1'b1);
    finish_job();
    chk("acc_C00", result[0*AW +: AW], 64'd20);
    chk("acc_C03", result[3*AW +: AW], 64'd80);
    chk("acc_C33", result[15*AW +: AW], 64'd464);

    // Stall of 3 cycles between beats 2 and 3
    stall[2] = 3;
    feed_job(1'b0, 1'b1);
    finish_job();
    chk("stall_C32", result[14*AW +: AW], 64'd174);

    // All-ones operands: wrap modulo 2^64
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = '1;
        B[i][k] = '1;
      end
    no_stall();
    feed_job(1'b0, 1'b1);
    finish_job();
    chk("wrap_C12", result[6*AW +: AW], 64'hFFFF_FFF8_0000_0004);

    // Reset during DRAIN aborts the job
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = $urandom;
        B[i][k] = $urandom;
      end
    feed_job(1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(|result), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) C_m[i][j] = 0;
    repeat (2*N + 2) @(posedge clk);
    #1;
    chk("abort_idle", 64'(busy), 64'd0);

    // Identity job after reset: C = M
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = (i == k) ? 32'd1 : 32'd0;
        B[i][k] = $urandom;
      end
    feed_job(1'b0, 1'b1);
    finish_job();
    chk("ident_C21", result[9*AW +: AW], 64'(B[2][1]));

    // Randomized jobs
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          case ($urandom_range(0, 7))
            0:       A[i][k] = '0;
            1:       A[i][k] = '1;
            default: A[i][k] = $urandom;
          endcase
          B[i][k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
      for (int k = 0; k < N; k++)
        stall[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      feed_job(1'($urandom), 1'b1);
      finish_job();
    end

    // N=2 build: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    @(posedge clk); #1;
    start2 = 1'b1; acc_mode2 = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b0;
    t2 = 0;
    valid2 = 1'b1; a_col2 = {32'd3, 32'd1}; b_row2 = {32'd6, 32'd5};
    @(negedge clk);
    chk("ready_n2", 64'(ready2), 64'd1);
    @(posedge clk); #1;
    a_col2 = {32'd4, 32'd2}; b_row2 = {32'd8, 32'd7};
    @(negedge clk);
    t2 = cyc;
    e2.res = {64'd50, 64'd43, 64'd22, 64'd19};
    e2.done_cyc = t2 + 3;
    q2.push_back(e2);
    @(posedge clk); #1;
    valid2 = 1'b0; a_col2 = '0; b_row2 = '0;
    while (cyc < t2 + 3) begin
      @(posedge clk); #1;
    end
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    chk("busy_after_done_n2", 64'(busy2), 64'd0);
    chk("scoreboard_drained_n2", 64'(q2.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
